// File: rtl/deserializer_1_to_16_align.sv
// Serial-to-16-bit deserializer with SYNC_WORD hunt, verify and lock.
// Define DESER_SYNC_STRIP_EN to suppress emission of markers while locked.
module deserializer_1_to_16_align #(
  parameter logic [15:0] SYNC_WORD  = 16'hF0F0,
  parameter int          LOCK_COUNT = 4,
  parameter int          MAX_GAP    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        locked,
  output logic        sync_err
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int GW = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((MAX_GAP == 0) ? 0 : MAX_GAP - 1);

`ifdef DESER_SYNC_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t          state, state_n;
  logic [14:0]     sr, sr_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [MW-1:0]   match_cnt, match_cnt_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic [15:0]     word_n;
  logic            wv_n, locked_n, se_n;
  logic [15:0]     nxt;
  logic            is_sync, boundary;

  assign nxt      = {sr, bit_in};
  assign is_sync  = (nxt == SYNC_WORD);
  assign boundary = (bit_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sr         <= '0;
      bit_cnt    <= '0;
      match_cnt  <= '0;
      gap_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bit_cnt    <= bit_cnt_n;
      match_cnt  <= match_cnt_n;
      gap_cnt    <= gap_cnt_n;
      word_out   <= word_n;
      word_valid <= wv_n;
      locked     <= locked_n;
      sync_err   <= se_n;
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    bit_cnt_n   = bit_cnt;
    match_cnt_n = match_cnt;
    gap_cnt_n   = gap_cnt;
    word_n      = word_out;
    wv_n        = 1'b0;
    locked_n    = locked;
    se_n        = 1'b0;
    if (bit_valid) begin
      sr_n      = nxt[14:0];
      bit_cnt_n = bit_cnt + 4'd1;
      unique case (state)
        HUNT: begin
          // sliding compare: any bit position may start a frame
          if (is_sync) begin
            bit_cnt_n   = '0;
            match_cnt_n = MW'(1);
            if (LOCK_COUNT == 1) begin
              state_n   = LOCKED;
              locked_n  = 1'b1;
              gap_cnt_n = '0;
            end else begin
              state_n = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_sync) begin
              match_cnt_n = match_cnt + MW'(1);
              if (match_cnt == MATCH_LAST) begin
                state_n   = LOCKED;
                locked_n  = 1'b1;
                gap_cnt_n = '0;
              end
            end else begin
              state_n     = HUNT;
              match_cnt_n = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (!(STRIP && is_sync)) begin
              word_n = nxt;
              wv_n   = 1'b1;
            end
            if (is_sync) begin
              gap_cnt_n = '0;
            end else begin
              gap_cnt_n = gap_cnt + GW'(1);
              // the word that expires the gap is still emitted above
              if (MAX_GAP != 0 && gap_cnt == GAP_LAST) begin
                state_n     = HUNT;
                locked_n    = 1'b0;
                se_n        = 1'b1;
                match_cnt_n = '0;
              end
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_1_to_16_align.sv
// Randomised bench for deserializer_1_to_16_align against a frame-level model.
// Honours DESER_SYNC_STRIP_EN the same way as the design.
module tb_deserializer_1_to_16_align;

  localparam logic [15:0] SYNC  = 16'hF0F0;
  localparam int          LOCKN = 4;
  localparam int          GAPN  = 64;

`ifdef DESER_SYNC_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        locked;
  logic        sync_err;

  int n_tests = 0;
  int n_fail  = 0;
  int wv_cnt  = 0;
  int se_cnt  = 0;

  logic [15:0] m_win;
  logic [15:0] m_word;
  int          m_pos, m_marks, m_gaps;
  bit          m_lock, m_wv, m_se;

  deserializer_1_to_16_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_win   = '0;
    m_word  = '0;
    m_pos   = 0;
    m_marks = 0;
    m_gaps  = 0;
    m_lock  = 0;
    m_wv    = 0;
    m_se    = 0;
  endtask

  // frame-level reference: one call per clock edge
  task automatic m_step(input logic v, input logic b);
    m_wv = 0;
    m_se = 0;
    if (v) begin
      m_win = {m_win[14:0], b};
      if (m_lock) begin
        if (m_pos == 15) begin
          if (!(STRIP && m_win == SYNC)) begin
            m_word = m_win;
            m_wv   = 1;
          end
          if (m_win == SYNC) m_gaps = 0;
          else begin
            m_gaps++;
            if (GAPN != 0 && m_gaps == GAPN) begin
              m_lock  = 0;
              m_se    = 1;
              m_marks = 0;
            end
          end
        end
        m_pos = (m_pos + 1) % 16;
      end else if (m_marks == 0) begin
        if (m_win == SYNC) begin
          m_marks = 1;
          m_pos   = 0;
          if (LOCKN == 1) begin
            m_lock = 1;
            m_gaps = 0;
          end
        end
      end else begin
        if (m_pos == 15) begin
          if (m_win == SYNC) begin
            m_marks++;
            if (m_marks == LOCKN) begin
              m_lock = 1;
              m_gaps = 0;
            end
          end else begin
            m_marks = 0;
          end
        end
        m_pos = (m_pos + 1) % 16;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic b);
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    m_step(v, b);
    #1;
    check("word_valid", word_valid, m_wv);
    check("locked", locked, m_lock);
    check("sync_err", sync_err, m_se);
    check("word_out", word_out, m_word);
    if (word_valid) wv_cnt++;
    if (sync_err) se_cnt++;
  endtask

  // idle < 0: random 0..2 idle cycles per bit, else that many
  task automatic send_word(input logic [15:0] w, input int idle);
    for (int i = 15; i >= 0; i--) begin
      int n;
      n = (idle < 0) ? int'($urandom_range(0, 2)) : idle;
      repeat (n) cyc(1'b0, 1'($urandom));
      cyc(1'b1, w[i]);
    end
  endtask

  task automatic send_sync(input int n, input int idle);
    repeat (n) send_word(SYNC, idle);
  endtask

  // asserted off the clock edge so the clear is seen before any edge
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    bit_in    = 1'($urandom);
    bit_valid = 1'($urandom);
    #1;
    check("rst_word_out", word_out, 16'h0);
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    bit_valid = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    logic [4:0] junk;
    m_reset();
    #1;
    do_reset();

    // basic lock then one data word
    send_sync(4, 0);
    check("s2_locked", locked, 1'b1);
    send_word(16'h1234, 0);
    check("s2_wv", word_valid, 1'b1);
    check("s2_word", word_out, 16'h1234);
    cyc(1'b0, 1'b0);
    check("s2_wv_pulse", word_valid, 1'b0);

    // bit slip before markers
    do_reset();
    wv_cnt = 0;
    junk = 5'b10110;
    for (int i = 4; i >= 0; i--) cyc(1'b1, junk[i]);
    send_sync(4, 0);
    check("s3_no_early_wv", wv_cnt, 0);
    check("s3_locked", locked, 1'b1);
    send_word(16'hABCD, 0);
    check("s3_wv", word_valid, 1'b1);
    check("s3_word", word_out, 16'hABCD);

    // failed verify
    do_reset();
    send_word(SYNC, 0);
    send_word(SYNC, 0);
    send_word(16'hF0F1, 0);
    check("s4_no_lock", locked, 1'b0);
    send_sync(3, 0);
    check("s4_not_yet", locked, 1'b0);
    send_sync(1, 0);
    check("s4_relock", locked, 1'b1);
    send_word(16'h5555, 0);
    check("s4_word", word_out, 16'h5555);

    // loss of lock after MAX_GAP data words
    do_reset();
    send_sync(4, 0);
    wv_cnt = 0;
    se_cnt = 0;
    repeat (63) send_word(16'h0000, 0);
    check("s5_no_err_63", se_cnt, 0);
    check("s5_lock_63", locked, 1'b1);
    send_word(16'h0000, 0);
    check("s5_err", sync_err, 1'b1);
    check("s5_unlocked", locked, 1'b0);
    check("s5_wv_cnt", wv_cnt, 64);
    cyc(1'b0, 1'b0);
    check("s5_err_pulse", sync_err, 1'b0);

    // marker at word 63 keeps lock
    do_reset();
    send_sync(4, 0);
    wv_cnt = 0;
    se_cnt = 0;
    repeat (62) send_word(16'h0000, 0);
    send_word(SYNC, 0);
    repeat (2) send_word(16'h0000, 0);
    check("s5b_locked", locked, 1'b1);
    check("s5b_no_err", se_cnt, 0);
    check("s5b_wv_cnt", wv_cnt, STRIP ? 64 : 65);

    // throttled input and mid-word reset
    do_reset();
    send_sync(4, 1);
    check("s6_locked", locked, 1'b1);
    send_word(16'h1234, 1);
    check("s6_wv", word_valid, 1'b1);
    check("s6_word", word_out, 16'h1234);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'($urandom));
    do_reset();
    send_sync(3, 1);
    check("s6_no_relock", locked, 1'b0);
    send_sync(1, 1);
    check("s6_relock", locked, 1'b1);
    send_word(16'hBEEF, 0);
    check("s6_word2", word_out, 16'hBEEF);

    // random traffic against the model
    do_reset();
    for (int w = 0; w < 400; w++) begin
      int r, idle;
      r    = int'($urandom_range(0, 9));
      idle = ($urandom_range(0, 1) != 0) ? -1 : 0;
      if (w % 100 == 50) begin
        repeat (70) send_word(16'($urandom), 0);
      end else if (r < 4) begin
        send_word(SYNC, idle);
      end else if (r < 9) begin
        send_word(16'($urandom), idle);
      end else begin
        repeat ($urandom_range(1, 7)) cyc(1'b1, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
